pixel_fetch_ctrl: RTL

Raster-order read-address sequencer for the daltonization pixel path. It walks a width x height image stored linearly in pixel SRAM and issues one read request per pixel over a req/ack handshake. It emits column and row indices plus end-of-line and end-of-frame strobes for the downstream colour-transform stage, and pulses done when the frame is complete.

---
 rtl/pixel_fetch_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/pixel_fetch_ctrl.sv
// Raster-order pixel SRAM read sequencer: one req/ack read per pixel, col/row indices, eol/eof strobes, done pulse.
// Optional macro FETCH_BACKPRESSURE_EN adds out_ready, which gates raising of rd_req.
module pixel_fetch_ctrl #(
  parameter int COL_BITS  = 10,
  parameter int ROW_BITS  = 10,
  parameter int ADDR_BITS = 20
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [COL_BITS-1:0]  img_width,
  input  logic [ROW_BITS-1:0]  img_height,
  input  logic [ADDR_BITS-1:0] base_addr,
`ifdef FETCH_BACKPRESSURE_EN
  input  logic                 out_ready,
`endif
  output logic                 rd_req,
  output logic [ADDR_BITS-1:0] rd_addr,
  input  logic                 rd_ack,
  output logic [COL_BITS-1:0]  col,
  output logic [ROW_BITS-1:0]  row,
  output logic                 eol,
  output logic                 eof,
  output logic                 busy,
  output logic                 done,
  output logic                 cfg_err
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DONE} state_t;

  state_t               r_state;
  logic [COL_BITS-1:0]  r_width_m1;
  logic [ROW_BITS-1:0]  r_height_m1;
  logic [ADDR_BITS-1:0] r_addr;
  logic [COL_BITS-1:0]  r_col;
  logic [ROW_BITS-1:0]  r_row;
  logic                 r_rd_req;
  logic                 r_eol;
  logic                 r_eof;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_cfg_err;

  logic w_dim_ok;
  logic w_accept;
  logic w_last_col;
  logic w_last_row;
  logic w_req_go;

  assign w_dim_ok   = (img_width != '0) && (img_height != '0);
  assign w_accept   = r_rd_req && rd_ack;
  assign w_last_col = (r_col == r_width_m1);
  assign w_last_row = (r_row == r_height_m1);

`ifdef FETCH_BACKPRESSURE_EN
  assign w_req_go = out_ready;
`else
  assign w_req_go = 1'b1;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state     <= S_IDLE;
      r_width_m1  <= '0;
      r_height_m1 <= '0;
      r_addr      <= '0;
      r_col       <= '0;
      r_row       <= '0;
      r_rd_req    <= 1'b0;
      r_eol       <= 1'b0;
      r_eof       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cfg_err   <= 1'b0;
    end else begin
      r_eol     <= 1'b0;
      r_eof     <= 1'b0;
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (!w_dim_ok) begin
              r_cfg_err <= 1'b1;
            end else begin
              r_width_m1  <= img_width - COL_BITS'(1);
              r_height_m1 <= img_height - ROW_BITS'(1);
              r_addr      <= base_addr;
              r_col       <= '0;
              r_row       <= '0;
              r_rd_req    <= w_req_go;
              r_busy      <= 1'b1;
              r_state     <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          // Abort beats a same-cycle ack: the pixel on the bus is not consumed.
          if (abort) begin
            r_rd_req <= 1'b0;
            r_busy   <= 1'b0;
            r_state  <= S_IDLE;
          end else if (w_accept) begin
            r_addr <= r_addr + ADDR_BITS'(1);
            if (w_last_col) begin
              r_col <= '0;
              r_row <= r_row + ROW_BITS'(1);
              r_eol <= 1'b1;
              if (w_last_row) begin
                r_eof    <= 1'b1;
                r_rd_req <= 1'b0;
                r_busy   <= 1'b0;
                r_state  <= S_DONE;
              end else begin
                r_rd_req <= w_req_go;
              end
            end else begin
              r_col    <= r_col + COL_BITS'(1);
              r_rd_req <= w_req_go;
            end
          end else if (!r_rd_req) begin
            r_rd_req <= w_req_go;
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rd_req  = r_rd_req;
  assign rd_addr = r_addr;
  assign col     = r_col;
  assign row     = r_row;
  assign eol     = r_eol;
  assign eof     = r_eof;
  assign busy    = r_busy;
  assign done    = r_done;
  assign cfg_err = r_cfg_err;

endmodule
